// File: rtl/coo_row_dot_if.sv
// Bundle of the X/Y join handshake and the registered result port of coo_row_dot.
// The master side (producer/consumer environment) drives X, Y and out_ready.
interface coo_row_dot_if #(
  parameter int NZN        = 4,
  parameter int M          = 2,
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int OUT_WIDTH  = 16
);
  logic [NZN-1:0][X_WIDTH-1:0]    x_data;
  logic [NZN-1:0][ADDR_WIDTH-1:0] x_row_table;
  logic [NZN-1:0][ADDR_WIDTH-1:0] x_col_table;
  logic [ADDR_WIDTH-1:0]          fetch_row;
  logic                           x_valid;
  logic                           x_ready;
  logic [M-1:0][Y_WIDTH-1:0]      y_data;
  logic                           y_valid;
  logic                           y_ready;
  logic [OUT_WIDTH-1:0]           out_data;
  logic                           overflow;
  logic                           out_valid;
  logic                           out_ready;

  modport master (
    output x_data, x_row_table, x_col_table, fetch_row, x_valid, y_data, y_valid, out_ready,
    input  x_ready, y_ready, out_data, overflow, out_valid
  );

  modport slave (
    input  x_data, x_row_table, x_col_table, fetch_row, x_valid, y_data, y_valid, out_ready,
    output x_ready, y_ready, out_data, overflow, out_valid
  );
endinterface

// File: rtl/coo_row_dot.sv
// Single-row COO sparse x dense dot product with a registered valid/ready result stage.
// Define COO_ROW_DOT_SAT_EN to saturate the rounded result instead of wrapping it.
module coo_row_dot #(
  parameter int NZN            = 4,
  parameter int FETCH_SIZE     = 2,
  parameter int M              = 2,
  parameter int X_WIDTH        = 8,
  parameter int X_FRAC_WIDTH   = 1,
  parameter int Y_WIDTH        = 8,
  parameter int Y_FRAC_WIDTH   = 1,
  parameter int ADDR_WIDTH     = 16,
  parameter int OUT_WIDTH      = 16,
  parameter int OUT_FRAC_WIDTH = 0
) (
  input  logic         clk,
  input  logic         rst,
  coo_row_dot_if.slave bus
);
  localparam int ACC_WIDTH = X_WIDTH + Y_WIDTH + $clog2(FETCH_SIZE);
  localparam int ACC_FRAC  = X_FRAC_WIDTH + Y_FRAC_WIDTH;
  localparam int SHIFT     = ACC_FRAC - OUT_FRAC_WIDTH;
  localparam int LSH       = (SHIFT < 0) ? -SHIFT : 0;
  localparam int EXT_A     = ACC_WIDTH + 1 + LSH;
  localparam int EXT_W     = (EXT_A > OUT_WIDTH + 1) ? EXT_A : OUT_WIDTH + 1;
  localparam int CNT_W     = $clog2(FETCH_SIZE + 1);
`ifdef COO_ROW_DOT_SAT_EN
  localparam int RND_W     = EXT_W;
`else
  localparam int RND_W     = OUT_WIDTH;
`endif

  logic        [CNT_W-1:0]      cnt_s;
  logic                         ovf_s;
  logic signed [X_WIDTH-1:0]    slot_x_s [FETCH_SIZE];
  logic        [ADDR_WIDTH-1:0] slot_c_s [FETCH_SIZE];
  logic signed [Y_WIDTH-1:0]    slot_y_s [FETCH_SIZE];
  logic signed [ACC_WIDTH-1:0]  acc_s;
  logic signed [EXT_W-1:0]      ext_s;
  logic signed [RND_W-1:0]      rnd_s;
  logic        [OUT_WIDTH-1:0]  fit_s;
  logic                         free_s;
  logic                         accept_s;

  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q,  out_data_d;
  logic                 overflow_q,  overflow_d;

  // Row fetch: the first FETCH_SIZE matching entries, in entry order, fill the slots.
  always_comb begin
    cnt_s = '0;
    ovf_s = 1'b0;
    for (int j = 0; j < FETCH_SIZE; j++) begin
      slot_x_s[j] = '0;
      slot_c_s[j] = '0;
    end
    for (int i = 0; i < NZN; i++) begin
      if (bus.x_row_table[i] == bus.fetch_row) begin
        if (cnt_s < CNT_W'(FETCH_SIZE)) begin
          for (int j = 0; j < FETCH_SIZE; j++) begin
            if (cnt_s == CNT_W'(j)) begin
              slot_x_s[j] = bus.x_data[i];
              slot_c_s[j] = bus.x_col_table[i];
            end else begin
              slot_x_s[j] = slot_x_s[j];
            end
          end
          cnt_s = cnt_s + CNT_W'(1);
        end else begin
          ovf_s = 1'b1;
        end
      end else begin
        ovf_s = ovf_s;
      end
    end
  end

  // Gather by column (out-of-range columns read as zero) and accumulate exactly.
  always_comb begin
    acc_s = '0;
    for (int j = 0; j < FETCH_SIZE; j++) begin
      slot_y_s[j] = '0;
      for (int m = 0; m < M; m++) begin
        if (slot_c_s[j] == ADDR_WIDTH'(m)) begin
          slot_y_s[j] = bus.y_data[m];
        end else begin
          slot_y_s[j] = slot_y_s[j];
        end
      end
      acc_s = acc_s + ACC_WIDTH'(slot_x_s[j]) * ACC_WIDTH'(slot_y_s[j]);
    end
  end

  assign ext_s = EXT_W'(acc_s);

  generate
    if (SHIFT > 0) begin : g_rnd_down
      localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) <<< (SHIFT - 1);
      assign rnd_s = RND_W'((ext_s + HALF) >>> SHIFT);
    end else if (SHIFT < 0) begin : g_rnd_up
      assign rnd_s = RND_W'(ext_s <<< LSH);
    end else begin : g_rnd_none
      assign rnd_s = RND_W'(ext_s);
    end
  endgenerate

`ifdef COO_ROW_DOT_SAT_EN
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Clamp the rounded value into the signed output range.
  always_comb begin
    if (rnd_s > SAT_MAX) begin
      fit_s = SAT_MAX[OUT_WIDTH-1:0];
    end else if (rnd_s < SAT_MIN) begin
      fit_s = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      fit_s = rnd_s[OUT_WIDTH-1:0];
    end
  end
`else
  assign fit_s = rnd_s;
`endif

  // Join handshake: each ready looks only at the opposite valid and the output stage.
  assign free_s      = !out_valid_q || bus.out_ready;
  assign accept_s    = bus.x_valid && bus.y_valid && free_s;
  assign bus.x_ready = bus.y_valid && free_s;
  assign bus.y_ready = bus.x_valid && free_s;

  // Output stage next state: a new accept wins over a simultaneous drain.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = fit_s;
      overflow_d  = ovf_s;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_coo_row_dot.sv
// Table-driven scoreboard bench for coo_row_dot (default widths plus an 8-bit output instance).
module tb_coo_row_dot;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coo_row_dot_if #(.NZN(4), .M(2), .X_WIDTH(8), .Y_WIDTH(8), .ADDR_WIDTH(16), .OUT_WIDTH(16)) bus ();
  coo_row_dot_if #(.NZN(4), .M(2), .X_WIDTH(8), .Y_WIDTH(8), .ADDR_WIDTH(16), .OUT_WIDTH(8))  bus8 ();

  coo_row_dot dut (.clk(clk), .rst(rst), .bus(bus));
  coo_row_dot #(.OUT_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    logic [3:0][15:0] xr;
    logic [3:0][15:0] xc;
    logic [3:0][7:0]  xd;
    logic [1:0][7:0]  yd;
    logic [15:0]      fr;
    logic [15:0]      ed;
    logic             eo;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        o;
  } exp_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  exp_t q [$];
  exp_t cur;
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input int i);
    bus.x_row_table = vecs[i].xr;
    bus.x_col_table = vecs[i].xc;
    bus.x_data      = vecs[i].xd;
    bus.y_data      = vecs[i].yd;
    bus.fetch_row   = vecs[i].fr;
    cur.d           = vecs[i].ed;
    cur.o           = vecs[i].eo;
  endtask

  task automatic send(input int i);
    int n = 0;
    @(posedge clk); #1;
    apply(i);
    bus.x_valid = 1'b1;
    bus.y_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.x_ready) break;
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: vector %0d not accepted within 50 cycles", i);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
    bus.y_valid = 1'b0;
  endtask

  // Scoreboard: pop on every drained result, push on every accepted transaction.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", bus.out_data);
        end else begin
          mon_e = q.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(mon_e.d));
          chk("overflow", 32'(bus.overflow), 32'(mon_e.o));
        end
      end
      if (bus.x_valid && bus.y_valid && bus.x_ready) q.push_back(cur);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    // Packed lists are written entry 3 first, entry 0 last.
    vecs[0]  = '{xr:{16'd1,16'd1,16'd0,16'd0}, xc:{16'd0,16'd1,16'd1,16'd0}, xd:{8'd8,8'd2,8'd6,8'd4},
                 yd:{8'd4,8'd2}, fr:16'd0, ed:16'd8, eo:1'b0};
    vecs[1]  = '{xr:{16'd1,16'd1,16'd0,16'd0}, xc:{16'd0,16'd1,16'd1,16'd0}, xd:{8'd8,8'd2,8'd6,8'd4},
                 yd:{8'd4,8'd2}, fr:16'd1, ed:16'd6, eo:1'b0};
    vecs[2]  = '{xr:{16'd5,16'd5,16'd5,16'd0}, xc:{16'd0,16'd0,16'd0,16'd0}, xd:{8'd9,8'd9,8'd9,8'd3},
                 yd:{8'd0,8'd2}, fr:16'd0, ed:16'd2, eo:1'b0};
    vecs[3]  = '{xr:{16'd5,16'd5,16'd5,16'd0}, xc:{16'd0,16'd0,16'd0,16'd0}, xd:{8'd9,8'd9,8'd9,8'hFD},
                 yd:{8'd0,8'd2}, fr:16'd0, ed:16'hFFFF, eo:1'b0};
    vecs[4]  = '{xr:{16'd3,16'd0,16'd0,16'd0}, xc:{16'd0,16'd0,16'd1,16'd0}, xd:{8'd9,8'd100,8'd2,8'd2},
                 yd:{8'd2,8'd2}, fr:16'd0, ed:16'd2, eo:1'b1};
    vecs[5]  = '{xr:{16'd5,16'd5,16'd5,16'd0}, xc:{16'd0,16'd0,16'd0,16'd5}, xd:{8'd9,8'd9,8'd9,8'd4},
                 yd:{8'd2,8'd2}, fr:16'd0, ed:16'd0, eo:1'b0};
    vecs[6]  = '{xr:{16'd1,16'd1,16'd0,16'd0}, xc:{16'd0,16'd1,16'd1,16'd0}, xd:{8'd8,8'd2,8'd6,8'd4},
                 yd:{8'd4,8'd2}, fr:16'd9, ed:16'd0, eo:1'b0};
    vecs[7]  = '{xr:{16'd4,16'd4,16'd2,16'd2}, xc:{16'd0,16'd0,16'd1,16'd1}, xd:{8'd9,8'd9,8'd3,8'd5},
                 yd:{8'd6,8'd1}, fr:16'd2, ed:16'd12, eo:1'b0};
    vecs[8]  = '{xr:{16'd5,16'd5,16'd5,16'd0}, xc:{16'd0,16'd0,16'd0,16'd0}, xd:{8'd0,8'd0,8'd0,8'hFF},
                 yd:{8'd0,8'd2}, fr:16'd0, ed:16'd0, eo:1'b0};
    vecs[9]  = '{xr:{16'd5,16'd5,16'd0,16'd0}, xc:{16'd0,16'd0,16'd1,16'd0}, xd:{8'd0,8'd0,8'h80,8'h80},
                 yd:{8'h80,8'h80}, fr:16'd0, ed:16'h2000, eo:1'b0};
    vecs[10] = '{xr:{16'd5,16'd5,16'd0,16'd0}, xc:{16'd0,16'd0,16'd1,16'd0}, xd:{8'd0,8'd0,8'h80,8'h80},
                 yd:{8'h7F,8'h7F}, fr:16'd0, ed:16'hE040, eo:1'b0};
    vecs[11] = '{xr:{16'h8000,16'h0000,16'h0000,16'h0100}, xc:{16'd0,16'h0100,16'd0,16'd0},
                 xd:{8'd9,8'd7,8'd1,8'd50}, yd:{8'd3,8'd2}, fr:16'd0, ed:16'd1, eo:1'b0};
    vecs[12] = '{xr:{16'd0,16'd0,16'd3,16'd0}, xc:{16'd0,16'd1,16'd0,16'd0}, xd:{8'd100,8'd1,8'd9,8'd1},
                 yd:{8'd4,8'd4}, fr:16'd0, ed:16'd2, eo:1'b1};

    bus.x_valid = 1'b0;  bus.y_valid = 1'b0;  bus.out_ready = 1'b1;
    bus.x_data = '0;  bus.x_row_table = '0;  bus.x_col_table = '0;  bus.y_data = '0;  bus.fetch_row = '0;
    bus8.x_valid = 1'b0; bus8.y_valid = 1'b0; bus8.out_ready = 1'b1;
    bus8.x_data = '0; bus8.x_row_table = '0; bus8.x_col_table = '0; bus8.y_data = '0; bus8.fetch_row = '0;
    cur = '0;

    // Reset state and ready equations while held in reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_x_ready_idle", 32'(bus.x_ready), 32'd0);
    bus.y_valid = 1'b1;
    #1;
    chk("x_ready_from_y_valid", 32'(bus.x_ready), 32'd1);
    chk("y_ready_without_x", 32'(bus.y_ready), 32'd0);
    bus.y_valid = 1'b0;
    rst = 1'b0;

    // Streamed table vectors, full throughput.
    for (int i = 0; i < NV; i++) send(i);
    idle();
    repeat (3) @(negedge clk);

    // Backpressure: hold a result, then release while offering the next one.
    bus.out_ready = 1'b0;
    send(0);
    @(posedge clk); #1;
    apply(1);
    repeat (3) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_out_data", 32'(bus.out_data), 32'(vecs[0].ed));
      chk("hold_x_ready", 32'(bus.x_ready), 32'd0);
      chk("hold_y_ready", 32'(bus.y_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_x_ready", 32'(bus.x_ready), 32'd1);
    @(posedge clk); #1;
    apply(2);
    @(negedge clk);
    chk("no_bubble_1", 32'(bus.out_valid), 32'd1);
    idle();
    @(negedge clk);
    chk("no_bubble_2", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    chk("drained", 32'(bus.out_valid), 32'd0);

    // X offered without Y: nothing is accepted.
    @(posedge clk); #1;
    apply(3);
    bus.x_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("xonly_x_ready", 32'(bus.x_ready), 32'd0);
      chk("xonly_y_ready", 32'(bus.y_ready), 32'd1);
      chk("xonly_out_valid", 32'(bus.out_valid), 32'd0);
    end
    idle();

    // Asynchronous reset while a result is held.
    bus.out_ready = 1'b0;
    send(4);
    idle();
    @(negedge clk);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_overflow", 32'(bus.overflow), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_out_data", 32'(bus.out_data), 32'd0);
    chk("async_rst_overflow", 32'(bus.overflow), 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // 8-bit output: saturation or wrap of 127*127*2.
    @(posedge clk); #1;
    bus8.x_row_table = {16'd5, 16'd5, 16'd0, 16'd0};
    bus8.x_col_table = {16'd0, 16'd0, 16'd1, 16'd0};
    bus8.x_data      = {8'd0, 8'd0, 8'd127, 8'd127};
    bus8.y_data      = {8'd127, 8'd127};
    bus8.fetch_row   = 16'd0;
    bus8.x_valid = 1'b1;
    bus8.y_valid = 1'b1;
    @(negedge clk);
    chk("w8_accept", 32'(bus8.x_ready), 32'd1);
    @(posedge clk); #1;
    bus8.x_valid = 1'b0;
    bus8.y_valid = 1'b0;
    @(negedge clk);
    chk("w8_out_valid", 32'(bus8.out_valid), 32'd1);
`ifdef COO_ROW_DOT_SAT_EN
    chk("w8_sat", 32'(bus8.out_data), 32'h7F);
`else
    chk("w8_wrap", 32'(bus8.out_data), 32'h81);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
